// File: rtl/mips_store_monitor.sv
// mips_store_monitor: captures processor stores into a masked shadow memory and replays written words in address order.
// Define STORE_MON_CHECKSUM_EN to build the running CHECKSUM accumulator (otherwise CHECKSUM is 0).
module mips_store_monitor #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic              CK,
  input  logic              RESET,
  input  logic              IN_VALID,
  input  logic [ADDR_W-1:0] IN_ADDR,
  input  logic [DATA_W-1:0] IN_DATA,
  input  logic              IN_DONE,
  output logic              RD_VALID,
  input  logic              RD_READY,
  output logic [ADDR_W-1:0] RD_ADDR,
  output logic [DATA_W-1:0] RD_DATA,
  output logic [CNT_W-1:0]  STORE_COUNT,
  output logic              LATE_STORE,
  output logic              ALL_DONE,
  output logic [DATA_W-1:0] CHECKSUM
);
  localparam int DEPTH = 2**ADDR_W;
  typedef enum logic [1:0] {CAPTURE, DRAIN, COMPLETE} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d, rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [DEPTH-1:0] written_q, written_d;
  logic [CNT_W-1:0] store_count_q, store_count_d;
  logic rd_valid_q, rd_valid_d, late_store_q, late_store_d, all_done_q, all_done_d;
  logic capture, advance;
  logic [DATA_W-1:0] mem [DEPTH];
  always_comb begin
    capture = state_q == CAPTURE && IN_VALID;
    advance = state_q == DRAIN && (rd_valid_q ? RD_READY : !written_q[ptr_q]);
    state_d = state_q;
    ptr_d = ptr_q;
    written_d = written_q;
    rd_valid_d = rd_valid_q;
    rd_addr_d = rd_addr_q;
    rd_data_d = rd_data_q;
    store_count_d = store_count_q;
    late_store_d = late_store_q | (IN_VALID && state_q != CAPTURE);
    all_done_d = all_done_q | (advance && &ptr_q);
    if (capture) begin
      written_d[IN_ADDR] = 1'b1;
      store_count_d = &store_count_q ? store_count_q : store_count_q + CNT_W'(1);
    end
    if (state_q == CAPTURE && IN_DONE) begin
      state_d = DRAIN;
      ptr_d = '0;
    end
    if (state_q == DRAIN && !rd_valid_q && written_q[ptr_q]) begin
      rd_valid_d = 1'b1;
      rd_addr_d = ptr_q;
      rd_data_d = mem[ptr_q];
    end
    // the last entry retires into COMPLETE rather than wrapping the sweep
    if (advance) begin
      rd_valid_d = 1'b0;
      ptr_d = ptr_q + ADDR_W'(1);
      state_d = &ptr_q ? COMPLETE : DRAIN;
    end
  end
  always_ff @(posedge CK) if (capture) mem[IN_ADDR] <= IN_DATA;
  always_ff @(posedge CK) begin
    if (RESET) begin
      state_q <= CAPTURE;
      ptr_q <= '0;
      written_q <= '0;
      rd_valid_q <= 1'b0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
      store_count_q <= '0;
      late_store_q <= 1'b0;
      all_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      written_q <= written_d;
      rd_valid_q <= rd_valid_d;
      rd_addr_q <= rd_addr_d;
      rd_data_q <= rd_data_d;
      store_count_q <= store_count_d;
      late_store_q <= late_store_d;
      all_done_q <= all_done_d;
    end
  end
  assign RD_VALID = rd_valid_q;
  assign RD_ADDR = rd_addr_q;
  assign RD_DATA = rd_data_q;
  assign STORE_COUNT = store_count_q;
  assign LATE_STORE = late_store_q;
  assign ALL_DONE = all_done_q;
`ifdef STORE_MON_CHECKSUM_EN
  logic [DATA_W-1:0] checksum_q, checksum_d;
  always_comb checksum_d = capture ? checksum_q + IN_DATA : checksum_q;
  always_ff @(posedge CK) checksum_q <= RESET ? '0 : checksum_d;
  assign CHECKSUM = checksum_q;
`else
  assign CHECKSUM = '0;
`endif
endmodule

// File: doc/mips_store_monitor.md
Name: mips_store_monitor

Overview:
- Receiving end of the processor's store-observation interface (valid / address / data / done).
- Captures every store into a shadow memory with a per-word written mask.
- When the processor signals done, replays the final image of each written word in ascending address order over a valid/ready readout port.
- Sits beside the processor in the test harness and feeds scoreboards or host readout logic.

Parameters:
- ADDR_W, 5, store address width; shadow depth is 2**ADDR_W words.
- DATA_W, 32, store data width.
- CNT_W, 8, width of the store counter.

Ports:
- CK  input  1  clock; all logic on the rising edge.
- RESET  input  1  synchronous reset, active-high.
- IN_VALID  input  1  store strobe from the processor.
- IN_ADDR  input  ADDR_W  store word address.
- IN_DATA  input  DATA_W  store data.
- IN_DONE  input  1  processor finished (level).
- RD_VALID  output  1  readout word available.
- RD_READY  input  1  readout consumer accepts.
- RD_ADDR  output  ADDR_W  readout word address.
- RD_DATA  output  DATA_W  readout word data.
- STORE_COUNT  output  CNT_W  stores captured, saturating.
- LATE_STORE  output  1  sticky: IN_VALID seen after capture closed.
- ALL_DONE  output  1  readout sweep complete.
- CHECKSUM  output  DATA_W  running sum of captured data (see Optional Feature).

Behaviour:
- Reset (synchronous, active-high):
  - State CAPTURE, ptr=0, written mask all 0.
  - RD_VALID=0, RD_ADDR=0, RD_DATA=0, STORE_COUNT=0, LATE_STORE=0, ALL_DONE=0, CHECKSUM=0.
  - Shadow RAM contents are not cleared; they are masked by the written mask.
  - Reset in any state, including mid-handshake, aborts immediately; a pending RD_VALID drops the next cycle.
- All outputs are registered.
- CAPTURE state:
  - IN_VALID=1: mem[IN_ADDR]<=IN_DATA, written[IN_ADDR]<=1, STORE_COUNT+1 (holds at all-ones).
  - Repeated stores to the same address: last write wins; each store is counted.
  - IN_DONE=1: next state DRAIN, ptr=0. If IN_VALID and IN_DONE occur in the same cycle, the store is captured first.
- DRAIN state, evaluated every cycle:
  - RD_VALID=0 and written[ptr]=1: load RD_ADDR=ptr, RD_DATA=mem[ptr], RD_VALID<=1.
  - RD_VALID=0 and written[ptr]=0: skip, 1 cycle per unwritten entry.
  - RD_VALID=1 and RD_READY=1: RD_VALID<=0, ptr advances.
  - RD_VALID=1 and RD_READY=0: RD_ADDR/RD_DATA held stable, no advance (no drop under backpressure).
  - Advancing past ptr=2**ADDR_W-1 goes to COMPLETE instead of wrapping.
  - Minimum 2 cycles per written word.
- COMPLETE state:
  - ALL_DONE=1, RD_VALID=0.
  - Stays until RESET; IN_DONE has no further effect.
- IN_VALID in DRAIN or COMPLETE: ignored (no memory, count or checksum update) and LATE_STORE<=1, sticky until reset.
- Zero stores before IN_DONE: sweep takes 2**ADDR_W cycles with no RD_VALID, then ALL_DONE.
- RD_READY while RD_VALID=0 has no effect.

Optional Feature:
- Macro STORE_MON_CHECKSUM_EN.
- Defined: CHECKSUM accumulates IN_DATA modulo 2**DATA_W on every captured store, in the same cycle memory is written; late stores are excluded.
- Undefined: no accumulator is built and CHECKSUM is tied to 0.
- Port list is identical in both builds.

Test Plan:
- Reset then stores (addr 0, 0x0), (1, 0x1), (2, 0x2), then IN_DONE, RD_READY=1 -> RD_VALID words (0,0x0), (1,0x1), (2,0x2) in order; ALL_DONE after sweeping to 31; STORE_COUNT=3.
- Stores (5, 0x1111) then (5, 0xBEEF), then IN_DONE -> single readout (5, 0xBEEF); STORE_COUNT=2; checksum build: CHECKSUM=0x0000D000.
- IN_VALID (7, 0xA5A5A5A5) and IN_DONE in the same cycle -> store captured; readout (7, 0xA5A5A5A5).
- Store (3, 0xCAFE), IN_DONE, RD_READY=0 for 10 cycles -> RD_VALID=1 with (3, 0xCAFE) stable throughout; accepted when RD_READY=1; ALL_DONE follows.
- After IN_DONE, IN_VALID (9, 0xDEAD) -> LATE_STORE=1; no readout at address 9; STORE_COUNT unchanged.
- Assert RESET mid-DRAIN with RD_VALID=1 -> next cycle all outputs 0, state CAPTURE; a new IN_DONE with no stores gives ALL_DONE after 32 cycles and no RD_VALID.
